// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants and types shared by the instruction fetch unit.
//   RESET_PC_DEFAULT : address of the first fetch after reset
//   INSTR_WIDTH      : width of one fetched instruction
//   fetch_state_e    : RUN (fetching) / DRAIN (dropping stale responses)
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_WIDTH      = 32;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry FIFO holding fetched {pc, instr} pairs.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   flush_i        : drop every entry (wins over push/pop)
//   push_i/_data_i : write one entry (accepted when not full, or when popping)
//   pop_i          : remove the head (ignored when empty)
//   head_o         : head entry, forced to zero while empty
//   empty_o        : no entries stored
//   count_o        : number of stored entries
module fetch_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             push_en;
  logic             pop_en;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_en  = pop_i && !empty_o;
  // A push into a full buffer is legal only when the head leaves the same cycle.
  assign push_en = push_i && (!full || pop_en);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_en && !pop_en) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!push_en && pop_en) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (push_en && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetcher with redirect and stale-response drain.
//   clk, rst                     : clock, asynchronous active-low reset
//   imem_req_valid/_ready/_addr  : fetch request to instruction memory
//   imem_rsp_valid/_data         : in-order memory response
//   redirect_valid/_pc           : taken branch / jump target
//   instr_valid/_ready, instr,
//   instr_pc                     : buffered instruction to decode
//   state_dbg                    : current fetch state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and the payload stays stable
// while valid is high and ready is low.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = INSTR_WIDTH,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned DEPTH         = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output fetch_state_e             state_dbg
);

  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
  localparam int unsigned PAYLOAD_W = ADDRESS_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  fetch_state_e             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]         outstanding_q, outstanding_d;
  logic [CNT_W-1:0]         discard_q, discard_d;

  logic [CNT_W-1:0]         buf_count;
  logic                     buf_empty;
  logic [PAYLOAD_W-1:0]     buf_head;
  logic [CNT_W:0]           occupancy;
  logic [ADDRESS_WIDTH-1:0] redirect_aligned;
  logic                     req_fire;
  logic                     rsp_keep;
  logic                     pop;
  logic                     unused_redirect_lsbs;

  // Fetch addresses are word aligned; the target's byte offset is ignored.
  assign redirect_aligned     = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Every in-flight request owns a buffer slot, so the buffer cannot overflow.
  assign occupancy      = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign imem_req_valid = rst && (state_q == RUN) && !redirect_valid && (occupancy < DEPTH_OCC);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses are kept only in RUN outside a redirect cycle; all others are stale.
  assign rsp_keep    = imem_rsp_valid && (state_q == RUN) && !redirect_valid;
  assign instr_valid = !buf_empty;
  assign pop         = instr_valid && instr_ready;
  assign {instr_pc, instr} = buf_head;
  assign state_dbg   = state_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    state_d       = state_q;

    if (req_fire && !imem_rsp_valid) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!req_fire && imem_rsp_valid) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end

    if (req_fire) fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(4);
    // Responses arrive in order, so the next kept one belongs to rsp_pc_q.
    if (rsp_keep) rsp_pc_d = rsp_pc_q + ADDRESS_WIDTH'(4);

    if (redirect_valid) begin
      // Everything still in flight after this cycle predates the redirect.
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      discard_d  = outstanding_d;
      state_d    = (outstanding_d != '0) ? DRAIN : RUN;
    end else if ((state_q == DRAIN) && imem_rsp_valid) begin
      discard_d = discard_q - CNT_W'(1);
      if (discard_q == CNT_W'(1)) state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // A redirect flushes after any same-cycle pop, so a consumed head is simply gone.
  fetch_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_buffer (
    .clk_i       (clk),
    .rst_ni      (rst),
    .flush_i     (redirect_valid),
    .push_i      (rsp_keep),
    .push_data_i ({rsp_pc_q, imem_rsp_data}),
    .pop_i       (pop),
    .head_o      (buf_head),
    .empty_o     (buf_empty),
    .count_o     (buf_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a latency-programmable memory model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef logic [31:0] word_q_t[$];

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [31:0]  imem_req_addr;
  logic         imem_rsp_valid;
  logic [31:0]  imem_rsp_data;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  fetch_state_e state_dbg;

  fetch_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (RST_PC),
    .DEPTH         (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .state_dbg      (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_lat  = 1;
  logic [31:0] exp_q[$];
  logic [31:0] req_addr_log[$];
  logic [31:0] req_cyc_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_data_log[$];
  logic [31:0] pop_cyc_log[$];
  logic [31:0] rsp_cyc_log[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          mem_cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] q_at(input word_q_t q, input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model: in-order, response visible mem_lat cycles after acceptance.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq_addr.delete();
      mq_due.delete();
      mem_cyc = 0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(mem_cyc + mem_lat - 1);
      end
      if (mq_addr.size() != 0 && mq_due[0] <= mem_cyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
      mem_cyc = mem_cyc + 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records handshakes that complete at the coming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      if (imem_req_valid && imem_req_ready) begin
        req_addr_log.push_back(imem_req_addr);
        req_cyc_log.push_back(32'(cyc));
      end
      if (instr_valid && instr_ready) begin
        pop_pc_log.push_back(instr_pc);
        pop_data_log.push_back(instr);
        pop_cyc_log.push_back(32'(cyc));
      end
      if (imem_rsp_valid) rsp_cyc_log.push_back(32'(cyc));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    req_addr_log.delete();
    req_cyc_log.delete();
    pop_pc_log.delete();
    pop_data_log.delete();
    pop_cyc_log.delete();
    rsp_cyc_log.delete();
    exp_q.delete();
  endtask

  task automatic apply_reset(input int lat, input logic rdy_instr, input logic rdy_req);
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step(2);
    clear_logs();
    mem_lat = lat;
    instr_ready = rdy_instr;
    imem_req_ready = rdy_req;
    rst = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    step(1);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_reqs(input int n, input int budget, input string tag);
    int k = 0;
    while (req_addr_log.size() < n && k < budget) begin
      step(1);
      k++;
    end
    if (req_addr_log.size() < n) check(tag, 32'(req_addr_log.size()), 32'(n));
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int k = 0;
    while (pop_pc_log.size() < n && k < budget) begin
      step(1);
      k++;
    end
    if (pop_pc_log.size() < n) check(tag, 32'(pop_pc_log.size()), 32'(n));
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_valid"},   32'(imem_req_valid), 32'd0);
    check({pfx, "_instr_valid"}, 32'(instr_valid),    32'd0);
    check({pfx, "_instr"},       instr,               32'd0);
    check({pfx, "_instr_pc"},    instr_pc,            32'd0);
    check({pfx, "_state"},       32'(state_dbg),      32'(RUN));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- tests ----------------
  initial begin
    rst = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step(2);
    check_reset_outputs("rst");

    // Streaming: sequential addresses, each instr one cycle after its response.
    apply_reset(1, 1'b1, 1'b1);
    exp_q = {32'h0, 32'h4, 32'h8};
    wait_pops(3, 40, "a_timeout");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("a_req_addr%0d", i), q_at(req_addr_log, i), exp_q[i]);
      check($sformatf("a_pop_pc%0d", i),   q_at(pop_pc_log, i),   exp_q[i]);
      check($sformatf("a_pop_instr%0d", i), q_at(pop_data_log, i), mem_word(exp_q[i]));
      check($sformatf("a_pop_lat%0d", i),  q_at(pop_cyc_log, i),  q_at(rsp_cyc_log, i) + 32'd1);
    end
    check("a_back_to_back", q_at(req_cyc_log, 1), q_at(req_cyc_log, 0) + 32'd1);

    // Back-pressure: buffer of 2 fills, then a pop frees a slot one cycle later.
    apply_reset(1, 1'b0, 1'b1);
    step(8);
    check("b_req_count", 32'(req_addr_log.size()), 32'd2);
    check("b_req_valid_low", 32'(imem_req_valid), 32'd0);
    check("b_head_pc", instr_pc, 32'h0);
    check("b_head_instr", instr, mem_word(32'h0));
    instr_ready = 1'b1;
    wait_reqs(3, 20, "b_timeout");
    check("b_req_after_pop", q_at(req_cyc_log, 2), q_at(pop_cyc_log, 0) + 32'd1);
    check("b_req2_addr", q_at(req_addr_log, 2), 32'h8);

    // Redirect with two requests in flight: both responses dropped in DRAIN.
    apply_reset(3, 1'b1, 1'b1);
    wait_reqs(2, 10, "c_timeout_req");
    redirect(32'h100);
    check("c_flush", 32'(instr_valid), 32'd0);
    check("c_state", 32'(state_dbg), 32'(DRAIN));
    check("c_no_req_drain", 32'(imem_req_valid), 32'd0);
    wait_pops(1, 40, "c_timeout_pop");
    check("c_req_addr", q_at(req_addr_log, 2), 32'h100);
    check("c_pop_pc", q_at(pop_pc_log, 0), 32'h100);
    check("c_pop_instr", q_at(pop_data_log, 0), mem_word(32'h100));

    // Redirect into a full buffer with an unaligned target.
    apply_reset(1, 1'b0, 1'b1);
    step(6);
    check("d_full", 32'(instr_valid), 32'd1);
    redirect(32'h203);
    check("d_flush", 32'(instr_valid), 32'd0);
    check("d_state", 32'(state_dbg), 32'(RUN));
    instr_ready = 1'b1;
    wait_pops(1, 20, "d_timeout");
    check("d_req_addr", q_at(req_addr_log, 2), 32'h200);
    check("d_pop_pc", q_at(pop_pc_log, 0), 32'h200);

    // Redirect in the same cycle as a response: that response counts as discarded.
    apply_reset(2, 1'b1, 1'b1);
    wait_reqs(2, 10, "e_timeout_req");
    redirect(32'h40);
    check("e_state", 32'(state_dbg), 32'(DRAIN));
    check("e_no_push", 32'(instr_valid), 32'd0);
    wait_pops(1, 30, "e_timeout_pop");
    check("e_req_addr", q_at(req_addr_log, 2), 32'h40);
    check("e_pop_pc", q_at(pop_pc_log, 0), 32'h40);

    // Stalled request holds its address; fetch address wraps past the top.
    apply_reset(1, 1'b1, 1'b0);
    step(1);
    check("f_req_valid", 32'(imem_req_valid), 32'd1);
    check("f_addr0", imem_req_addr, RST_PC);
    step(2);
    check("f_addr_hold", imem_req_addr, RST_PC);
    redirect(32'hFFFF_FFFC);
    check("f_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    wait_pops(2, 20, "f_timeout");
    check("f_req0", q_at(req_addr_log, 0), 32'hFFFF_FFFC);
    check("f_req1", q_at(req_addr_log, 1), 32'h0);
    check("f_pop0", q_at(pop_pc_log, 0), 32'hFFFF_FFFC);
    check("f_pop1", q_at(pop_pc_log, 1), 32'h0);

    // Reset in the middle of DRAIN abandons everything in flight.
    apply_reset(4, 1'b1, 1'b1);
    wait_reqs(2, 10, "g_timeout_req");
    redirect(32'h300);
    check("g_state", 32'(state_dbg), 32'(DRAIN));
    rst = 1'b0;
    #1;
    check_reset_outputs("g");
    clear_logs();
    step(2);
    rst = 1'b1;
    wait_pops(1, 20, "g_timeout_pop");
    check("g_req_addr", q_at(req_addr_log, 0), RST_PC);
    check("g_pop_pc", q_at(pop_pc_log, 0), RST_PC);
    check("g_pop_instr", q_at(pop_data_log, 0), mem_word(RST_PC));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
